// File: rtl/sq_recon.sv
// sq_recon: rebuilds d = q*q + r by 16-cycle shift-add and flags illegal root/remainder pairs
module sq_recon (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] q,
  input  logic [16:0] r,
  output logic [31:0] d,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state;
  logic [15:0] mcand, mplier;
  logic [32:0] acc, acc_nx;
  logic [3:0]  cnt;
  logic        err_next;
  // the final partial product must land in d on the same edge that leaves CALC
  assign acc_nx = acc + (mplier[0] ? ({17'b0, mcand} << cnt) : 33'd0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_next <= 1'b0;
      d        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= CALC;
          mcand    <= q;
          mplier   <= q;
          acc      <= {16'b0, r};
          cnt      <= '0;
          err_next <= r > {q, 1'b0};
          busy     <= 1'b1;
        end
        CALC: begin
          acc    <= acc_nx;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            d     <= acc_nx[31:0];
            err   <= err_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sq_recon.sv
// tb_sq_recon: directed and randomized checks of sq_recon against q*q+r and r>2q
module tb_sq_recon;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] q = '0;
  logic [16:0] r = '0;
  logic [31:0] d;
  logic        busy, done, err;
  int          tests = 0, fails = 0, cyc = 0;

  sq_recon dut (.clk(clk), .rst(rst), .start(start), .q(q), .r(r), .d(d), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse at E0, then count edges to done and cycles with busy high
  task automatic run(input string tag, input logic [15:0] qv, input logic [16:0] rv,
                     input logic [31:0] dx, input logic ex, input bit timing);
    int n = 0, bc = 0;
    q = qv; r = rv; start = 1'b1;
    tick();
    start = 1'b0;
    q = ~qv; r = ~rv;
    if (busy) bc++;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) bc++;
    end
    if (timing) begin
      chk({tag, "_lat"}, 33'(n), 33'd16);
      chk({tag, "_busy"}, 33'(bc), 33'd16);
      chk({tag, "_busy_off"}, 33'(busy), 33'd0);
    end
    chk({tag, "_d"}, 33'(d), 33'(dx));
    chk({tag, "_err"}, 33'(err), 33'(ex));
    tick();
    chk({tag, "_pulse"}, 33'(done), 33'd0);
  endtask

  initial begin
    logic [15:0] qv;
    logic [16:0] rv;
    logic [32:0] m;
    int t1, n;
    bit seen;
    tick();
    tick();
    chk("rst_d", 33'(d), 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_done", 33'(done), 33'd0);
    chk("rst_err", 33'(err), 33'd0);
    rst = 1'b0;

    run("v1", 16'h0005, 17'h00003, 32'h0000001C, 1'b0, 1'b1);
    run("v2a", 16'hFFFF, 17'h1FFFE, 32'hFFFFFFFF, 1'b0, 1'b1);
    run("v2b", 16'hFFFF, 17'h1FFFF, 32'h00000000, 1'b1, 1'b1);
    run("v3", 16'h4444, 17'h02468, 32'h12345678, 1'b0, 1'b1);
    run("v4a", 16'h0003, 17'h00007, 32'h00000010, 1'b1, 1'b1);
    run("v4b", 16'h0000, 17'h00000, 32'h00000000, 1'b0, 1'b1);
    run("q0", 16'h0000, 17'h1ABCD, 32'h0001ABCD, 1'b1, 1'b1);

    // back-to-back with start held high
    q = 16'h4444; r = 17'h02468; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    t1 = cyc;
    chk("v3bb_d1", 33'(d), 33'h12345678);
    q = 16'h0003; r = 17'h00002;
    tick();
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("v3bb_gap", 33'(cyc - t1), 33'd18);
    chk("v3bb_d2", 33'(d), 33'h0000000B);
    start = 1'b0;
    tick();
    tick();

    // second start mid-CALC is ignored
    q = 16'h0005; r = 17'h00003; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    q = 16'hFFFF; r = 17'h1FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    n = 5;
    while (!done && n < 40) begin tick(); n++; end
    chk("v5_lat", 33'(n), 33'd16);
    chk("v5_d", 33'(d), 33'h0000001C);
    chk("v5_err", 33'(err), 33'd0);
    repeat (3) tick();
    chk("v5_noq_done", 33'(done), 33'd0);
    chk("v5_noq_busy", 33'(busy), 33'd0);

    // reset at E8 aborts; restart at E10
    q = 16'h4444; r = 17'h02468; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    repeat (7) begin tick(); seen |= done; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("v6_busy", 33'(busy), 33'd0);
    chk("v6_d", 33'(d), 33'd0);
    chk("v6_done", 33'(done | seen), 33'd0);
    tick();
    chk("v6_d_e9", 33'(d), 33'd0);
    run("v6r", 16'h1234, 17'h00100, 32'h014B5B90, 1'b0, 1'b1);

    // randomized against reference model, corners first
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin qv = 16'h0000; rv = 17'h00000; end
        1: begin qv = 16'h0000; rv = 17'h1FFFF; end
        2: begin qv = 16'hFFFF; rv = 17'h00000; end
        3: begin qv = 16'hFFFF; rv = 17'h1FFFF; end
        4: begin qv = 16'hFFFF; rv = 17'h1FFFE; end
        5: begin qv = 16'h0001; rv = 17'h00002; end
        default: begin
          qv = 16'($urandom);
          rv = ($urandom % 2) ? 17'($urandom_range(0, 2 * int'(qv))) : 17'($urandom);
        end
      endcase
      m = 33'(qv) * 33'(qv) + 33'(rv);
      run("rnd", qv, rv, m[31:0], rv > 17'(2 * int'(qv)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sq_recon.md
SQ_RECON -- requirements
Module: sq_recon

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- q  in  16  root operand
- r  in  17  remainder operand
- d  out  32  reconstructed radicand, d = q*q + r
- busy  out  1  high while in CALC
- done  out  1  one-cycle completion pulse
- err  out  1  operand pair is not a legal root/remainder; valid with done, held until the next accept

Function
REQ-003 The block SHALL be the inverse of the restoring square-root unit: it reconstructs d from (q, r) and checks that (q, r) is a legal result.
REQ-004 States SHALL be IDLE, CALC and DONE.
- IDLE->CALC on start=1.
- CALC->DONE after the 16th iteration.
- DONE->IDLE unconditionally after one cycle.
REQ-005 On accept (an edge with state IDLE and start=1), the block SHALL:
- latch q into a 16-bit multiplicand register and into a 16-bit multiplier shift register;
- load a 33-bit accumulator with {16'b0, r};
- clear the 4-bit iteration counter;
- capture err_next = (r > {q,1'b0}), using a 17-bit compare.
REQ-006 CALC iteration i (0..15), one per clock, SHALL:
- if multiplier bit 0 = 1, add ({17'b0, mcand} << i) to the accumulator in 33-bit arithmetic;
- shift the multiplier right by 1;
- increment the counter.
REQ-007 The CALC->DONE transition SHALL occur on the edge where counter = 15.
REQ-008 Latency: if start is sampled at edge E0, done SHALL be high for exactly the cycle following edge E16, and busy SHALL be high from E1 through E16.
REQ-009 On the E16 edge, d SHALL load accumulator[31:0] and err SHALL load err_next.
- Both SHALL hold until the next result is loaded or rst is asserted.
REQ-010 start SHALL be ignored in CALC and DONE.
- No queuing.
- Latched operands SHALL be unaffected by changes on q or r after accept.
REQ-011 Width rule: the maximum legal sum is 0xFFFFFFFF (q=0xFFFF, r=0x1FFFE).
- Any sum with accumulator[32]=1 SHALL imply err=1; this holds automatically because such a sum requires r > 2q.
- d SHALL still present accumulator[31:0].
REQ-012 q=0 SHALL produce d={15'b0, r} after the full 16 cycles, with no early termination.
REQ-013 When start is held high continuously, the block SHALL accept again in the cycle after DONE, giving one result per 18 cycles.

Reset
REQ-014 An edge with rst=1 SHALL, regardless of state or start:
- force IDLE;
- set d=0, busy=0, done=0, err=0;
- clear the counter, accumulator and operand registers.
REQ-015 rst SHALL take priority over start on the same edge.
REQ-016 A reset during CALC SHALL abort the operation with no done pulse, and d SHALL read 0 afterwards.
REQ-017 After rst is deasserted, the block SHALL accept start on the first edge.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- V1: q=0x0005, r=0x00003, start at E0 -> done only after E16; d=0x0000001C, err=0; busy high E1..E16.
- V2: q=0xFFFF, r=0x1FFFE -> d=0xFFFFFFFF, err=0. Then q=0xFFFF, r=0x1FFFF -> d=0x00000000, err=1 (overflow).
- V3: q=0x4444, r=0x02468 (the sqrt unit's output for d=0x12345678) -> d=0x12345678, err=0. A back-to-back variant holds start high: the second accept occurs the cycle after done, and the second done follows 18 cycles after the first.
- V4: q=0x0003, r=0x00007 -> d=0x00000010, err=1 (7 > 6). q=0x0000, r=0x00000 -> d=0, err=0.
- V5: start pulsed again at E5 with different q/r during CALC -> ignored; the result matches the first operands.
- V6: rst asserted at E8 mid-CALC -> busy=0 and d=0 from E9, with no done. A new start at E10 completes normally after E26.
REQ-019 The bench SHALL run a randomized self-check against a reference model computing q*q+r and r>2q, with at least 1000 operand pairs, including all-ones and zero corner values.
